// File: rtl/inst_encoder_if.sv
// Bundle for inst_encoder: instruction-field inputs, address load, and the output FIFO head.
// The loader side uses the master modport; the encoder uses the slave modport.
interface inst_encoder_if #(
  parameter int COUNT_W = 16
);
  logic               i_valid;
  logic               o_ready;
  logic [2:0]         i_imm_sel;
  logic [6:0]         i_opcode;
  logic [4:0]         i_rd;
  logic [4:0]         i_rs1;
  logic [4:0]         i_rs2;
  logic [2:0]         i_funct3;
  logic [6:0]         i_funct7;
  logic [31:0]        i_imm;
  logic               i_addr_load;
  logic [31:0]        i_base_addr;
  logic               o_valid;
  logic               i_ready;
  logic [31:0]        o_inst;
  logic [31:0]        o_addr;
  logic               o_imm_err;
  logic               o_err_sticky;
  logic [COUNT_W-1:0] o_count;

  modport master (
    output i_valid, i_imm_sel, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7,
           i_imm, i_addr_load, i_base_addr, i_ready,
    input  o_ready, o_valid, o_inst, o_addr, o_imm_err, o_err_sticky, o_count
  );

  modport slave (
    input  i_valid, i_imm_sel, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7,
           i_imm, i_addr_load, i_base_addr, i_ready,
    output o_ready, o_valid, o_inst, o_addr, o_imm_err, o_err_sticky, o_count
  );
endinterface

// File: rtl/inst_encoder.sv
// RISC-V instruction encoder: packs fields + immediate into a word, tags it with a byte address, queues it in a 2-entry FIFO.
// Optional immediate range checking is enabled by defining INST_ENC_RANGE_CHECK_EN.
module inst_encoder #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          COUNT_W    = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  inst_encoder_if.slave bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } entry_t;

  entry_t             fifo_mem [2];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [31:0]        addr_cnt;
  logic               err_sticky;
  logic [COUNT_W-1:0] count;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [31:0] imm;
  logic [31:0] enc_inst;
  logic        bad_sel;
  logic        enc_err;
  entry_t      push_entry;

  assign imm   = bus.i_imm;
  // Extra wrap bit on each pointer tells full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[0] == rd_ptr[0]) && (wr_ptr[1] != rd_ptr[1]);
  assign push  = bus.i_valid && !full;
  assign pop   = !empty && bus.i_ready;

  always_comb begin
    enc_inst = NOP;
    bad_sel  = 1'b0;
    case (bus.i_imm_sel)
      3'd0: enc_inst = {imm[11:0], bus.i_rs1, bus.i_funct3, bus.i_rd, bus.i_opcode};
      3'd1: enc_inst = {bus.i_funct7, imm[4:0], bus.i_rs1, bus.i_funct3, bus.i_rd, bus.i_opcode};
      3'd2: enc_inst = {imm[11:5], bus.i_rs2, bus.i_rs1, bus.i_funct3, imm[4:0], bus.i_opcode};
      3'd3: enc_inst = {imm[12], imm[10:5], bus.i_rs2, bus.i_rs1, bus.i_funct3,
                        imm[4:1], imm[11], bus.i_opcode};
      3'd4: enc_inst = {imm[31:12], bus.i_rd, bus.i_opcode};
      3'd5: enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], bus.i_rd, bus.i_opcode};
      default: begin
        enc_inst = NOP;
        bad_sel  = 1'b1;
      end
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  logic chk_err;

  // Each format flags an immediate that its encoded bits cannot represent.
  always_comb begin
    chk_err = 1'b0;
    case (bus.i_imm_sel)
      3'd0, 3'd2: chk_err = !((&imm[31:11]) || !(|imm[31:11]));
      3'd1:       chk_err = |imm[31:5];
      3'd3:       chk_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      3'd4:       chk_err = |imm[11:0];
      3'd5:       chk_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:    chk_err = 1'b0;
    endcase
  end

  assign enc_err = bad_sel || chk_err;
`else
  assign enc_err = bad_sel;
`endif

  assign push_entry.addr = bus.i_addr_load ? bus.i_base_addr : addr_cnt;
  assign push_entry.inst = enc_inst;
  assign push_entry.err  = enc_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      addr_cnt    <= RESET_ADDR;
      err_sticky  <= 1'b0;
      count       <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr[0]] <= push_entry;
        wr_ptr              <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      // A load wins over the increment; a coincident accept consumes the loaded address.
      if (bus.i_addr_load) begin
        addr_cnt <= push ? bus.i_base_addr + 32'd4 : bus.i_base_addr;
      end else if (push) begin
        addr_cnt <= addr_cnt + 32'd4;
      end
      if (push && enc_err) begin
        err_sticky <= 1'b1;
      end else if (bus.i_addr_load) begin
        err_sticky <= 1'b0;
      end
      if (push && !(&count)) begin
        count <= count + COUNT_W'(1);
      end
    end
  end

  assign bus.o_ready      = !full;
  assign bus.o_valid      = !empty;
  assign bus.o_inst       = fifo_mem[rd_ptr[0]].inst;
  assign bus.o_addr       = fifo_mem[rd_ptr[0]].addr;
  assign bus.o_imm_err    = fifo_mem[rd_ptr[0]].err;
  assign bus.o_err_sticky = err_sticky;
  assign bus.o_count      = count;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed vectors push expected words, a negedge monitor checks each popped head.
// Error expectations follow INST_ENC_RANGE_CHECK_EN when it is defined for the build.
module tb_inst_encoder;

  localparam int CW = 4;

`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit checkEn = 1'b1;
`else
  localparam bit checkEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } ExpEntry;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  inst_encoder_if #(.COUNT_W(CW)) bus ();

  inst_encoder #(
    .RESET_ADDR(32'h0000_0000),
    .COUNT_W   (CW)
  ) dut (
    .i_clk(clock),
    .i_rst(reset),
    .bus  (bus)
  );

  ExpEntry     scoreboard[$];
  ExpEntry     monEntry;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] expAddr     = 32'h0;
  int          expCount    = 0;
  logic        expSticky   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: whenever the head is about to be popped, compare it with the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && bus.o_valid && bus.i_ready) begin
      if (scoreboard.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_word: got inst 0x%08h at 0x%08h, expected no word", bus.o_inst, bus.o_addr);
      end else begin
        monEntry = scoreboard.pop_front();
        checkOutput("head_inst", bus.o_inst, monEntry.inst);
        checkOutput("head_addr", bus.o_addr, monEntry.addr);
        checkOutput("head_err", {31'b0, bus.o_imm_err}, {31'b0, monEntry.err});
      end
    end
  end

  // Offer one word, wait (bounded) for o_ready, and record the expected FIFO entry.
  task automatic applyStimulus(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm, input logic [31:0] expInst,
                               input bit rangeBad, input bit load, input logic [31:0] base);
    ExpEntry e;
    int waitCnt;
    bus.i_imm_sel = sel;
    bus.i_opcode  = op;
    bus.i_rd      = rd;
    bus.i_rs1     = rs1;
    bus.i_rs2     = rs2;
    bus.i_funct3  = f3;
    bus.i_funct7  = f7;
    bus.i_imm     = imm;
    bus.i_valid   = 1'b1;
    waitCnt = 0;
    while (!bus.o_ready && waitCnt < 50) begin
      @(posedge clock);
      #1;
      waitCnt++;
    end
    if (!bus.o_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: got o_ready 0 after %0d cycles, expected 1", waitCnt);
      bus.i_valid = 1'b0;
      return;
    end
    bus.i_addr_load = load;
    bus.i_base_addr = base;
    e.inst = expInst;
    e.addr = load ? base : expAddr;
    e.err  = (sel >= 3'd6) || (checkEn && rangeBad);
    scoreboard.push_back(e);
    expAddr  = e.addr + 32'd4;
    expCount = (expCount < (1 << CW) - 1) ? expCount + 1 : expCount;
    if (e.err) expSticky = 1'b1;
    else if (load) expSticky = 1'b0;
    @(posedge clock);
    #1;
    bus.i_valid     = 1'b0;
    bus.i_addr_load = 1'b0;
  endtask

  task automatic pulseLoad(input logic [31:0] base);
    bus.i_addr_load = 1'b1;
    bus.i_base_addr = base;
    @(posedge clock);
    #1;
    bus.i_addr_load = 1'b0;
    expAddr   = base;
    expSticky = 1'b0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    #1;
    checkOutput("rst_async_valid", {31'b0, bus.o_valid}, 32'h0);
    checkOutput("rst_async_ready", {31'b0, bus.o_ready}, 32'h1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    scoreboard.delete();
    expAddr   = 32'h0;
    expCount  = 0;
    expSticky = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (scoreboard.size() != 0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("drain_left", scoreboard.size(), 32'h0);
  endtask

  initial begin
    logic [31:0] heldInst;
    bus.i_valid     = 1'b0;
    bus.i_ready     = 1'b1;
    bus.i_imm_sel   = 3'd0;
    bus.i_opcode    = 7'h0;
    bus.i_rd        = 5'd0;
    bus.i_rs1       = 5'd0;
    bus.i_rs2       = 5'd0;
    bus.i_funct3    = 3'd0;
    bus.i_funct7    = 7'h0;
    bus.i_imm       = 32'h0;
    bus.i_addr_load = 1'b0;
    bus.i_base_addr = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    checkOutput("reset_valid", {31'b0, bus.o_valid}, 32'h0);
    checkOutput("reset_ready", {31'b0, bus.o_ready}, 32'h1);
    checkOutput("reset_inst", bus.o_inst, 32'h0);
    checkOutput("reset_addr", bus.o_addr, 32'h0);
    checkOutput("reset_err", {31'b0, bus.o_imm_err}, 32'h0);
    checkOutput("reset_sticky", {31'b0, bus.o_err_sticky}, 32'h0);
    checkOutput("reset_count", {28'b0, bus.o_count}, 32'h0);

    // Basic formats: addi, sw, beq, srai, jal, lui
    applyStimulus(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h0050_0093, 0, 0, 32'h0);
    checkOutput("latency_valid", {31'b0, bus.o_valid}, 32'h1);
    applyStimulus(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8, 32'h0020_A423, 0, 0, 32'h0);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 0, 0, 32'h0);
    applyStimulus(3'd1, 7'h13, 5'd3, 5'd3, 5'd0, 3'd5, 7'h20, 32'd7, 32'h4071_D193, 0, 0, 32'h0);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFF8, 32'hFF9F_F0EF, 0, 0, 32'h0);
    applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 0, 0, 32'h0);
    checkOutput("sticky_clean", {31'b0, bus.o_err_sticky}, {31'b0, expSticky});
    applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h1234_52B7, 1, 0, 32'h0);
    checkOutput("sticky_lui", {31'b0, bus.o_err_sticky}, {31'b0, expSticky});

    // Out-of-range immediates, then a plain load clears the sticky flag
    applyStimulus(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 32'h8000_0093, 1, 0, 32'h0);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096, 32'h8000_0063, 1, 0, 32'h0);
    checkOutput("sticky_range", {31'b0, bus.o_err_sticky}, {31'b0, expSticky});
    pulseLoad(32'h0000_0200);
    checkOutput("sticky_cleared", {31'b0, bus.o_err_sticky}, 32'h0);

    // Invalid select accepted together with a load: sets sticky regardless of build
    applyStimulus(3'd6, 7'h33, 5'd2, 5'd3, 5'd4, 3'd0, 7'h00, 32'h0, 32'h0000_0013, 0, 1, 32'h0000_0300);
    checkOutput("sticky_set_wins", {31'b0, bus.o_err_sticky}, 32'h1);
    applyStimulus(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 32'h0000_0013, 0, 0, 32'h0);
    waitDrain();

    // Load coincident with accept, then counter increments
    resetDut();
    applyStimulus(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h0050_0093, 0, 1, 32'h0000_0100);
    checkOutput("count_one", {28'b0, bus.o_count}, 32'd1);
    applyStimulus(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 32'h0000_0013, 0, 0, 32'h0);
    checkOutput("count_two", {28'b0, bus.o_count}, 32'd2);
    waitDrain();

    // Backpressure: two words fill the FIFO, the third waits until i_ready returns
    resetDut();
    bus.i_ready = 1'b0;
    fork
      begin
        applyStimulus(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 32'h0050_0093, 0, 0, 32'h0);
        applyStimulus(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8, 32'h0020_A423, 0, 0, 32'h0);
        applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 0, 0, 32'h0);
      end
      begin
        repeat (4) @(posedge clock);
        #1;
        checkOutput("full_ready_low", {31'b0, bus.o_ready}, 32'h0);
        checkOutput("full_count", {28'b0, bus.o_count}, 32'd2);
        checkOutput("stall_head_addr", bus.o_addr, 32'h0);
        heldInst = bus.o_inst;
        @(posedge clock);
        #1;
        checkOutput("stall_head_held", bus.o_inst, 32'h0050_0093);
        checkOutput("stall_head_stable", bus.o_inst, heldInst);
        bus.i_ready = 1'b1;
      end
    join
    waitDrain();

    // Reset with entries queued discards them
    bus.i_ready = 1'b0;
    applyStimulus(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 32'h0000_0013, 0, 0, 32'h0);
    applyStimulus(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 32'h0000_0013, 0, 0, 32'h0);
    resetDut();
    checkOutput("post_rst_valid", {31'b0, bus.o_valid}, 32'h0);
    checkOutput("post_rst_count", {28'b0, bus.o_count}, 32'h0);
    bus.i_ready = 1'b1;

    // Address wrap and counter saturation
    pulseLoad(32'hFFFF_FFFC);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 32'h0000_0013, 0, 0, 32'h0);
    end
    waitDrain();
    checkOutput("count_saturated", {28'b0, bus.o_count}, 32'd15);
    checkOutput("count_model", {28'b0, bus.o_count}, expCount);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
